// File: rtl/rename_dispatch.sv
// rename_dispatch: RAT rename with intra-group bypass, bit-vector free list, commit tracking and one-cycle flush recovery
module rename_dispatch #(
    parameter int WIDTH  = 4,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6,
    parameter int NPREG  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_lane_valid,
    input  logic [WIDTH*AREG_W-1:0]   in_rdst,
    input  logic [WIDTH*AREG_W-1:0]   in_src1,
    input  logic [WIDTH*AREG_W-1:0]   in_src2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_lane_valid,
    output logic [WIDTH*PREG_W-1:0]   out_src1,
    output logic [WIDTH*PREG_W-1:0]   out_src2,
    output logic [WIDTH*PREG_W-1:0]   out_pdst,
    output logic [WIDTH*PREG_W-1:0]   out_old_pdst,
    input  logic [WIDTH-1:0]          commit_valid,
    input  logic [WIDTH*AREG_W-1:0]   commit_areg,
    input  logic [WIDTH*PREG_W-1:0]   commit_pdst,
    input  logic                      flush
);
    localparam int NAREG = 2**AREG_W;
    localparam logic [NPREG-1:0] FREE_INIT = {NPREG{1'b1}} << NAREG;

    logic [PREG_W-1:0] rat [NAREG];
    logic [PREG_W-1:0] crat [NAREG];
    logic [PREG_W-1:0] rat_n [NAREG];
    logic [PREG_W-1:0] crat_n [NAREG];
    logic [NPREG-1:0] free_vec, cfree_vec, free_n, cfree_n, alloc_mask, freed_mask;
    logic [WIDTH*PREG_W-1:0] s1, s2, pd, opd;
    logic [WIDTH-1:0] lane_alloc;
    logic accept;

    assign in_ready = rst_n && (!out_valid || out_ready) && !flush && ($countones(free_vec) >= WIDTH);
    assign accept = in_valid && in_ready;

    // Rename the offered group: lowest free pregs in lane order, sources bypassed from the youngest older writer
    always_comb begin
        logic [NPREG-1:0] avail;
        logic [AREG_W-1:0] rd, a1, a2, jd;
        logic [PREG_W-1:0] v1, v2, vo, jp, sel;
        logic found;
        avail = free_vec;
        lane_alloc = '0;
        s1 = '0;
        s2 = '0;
        pd = '0;
        opd = '0;
        for (int k = 0; k < WIDTH; k++) begin
            rd = in_rdst[k*AREG_W +: AREG_W];
            a1 = in_src1[k*AREG_W +: AREG_W];
            a2 = in_src2[k*AREG_W +: AREG_W];
            v1 = (a1 == '0) ? '0 : rat[a1];
            v2 = (a2 == '0) ? '0 : rat[a2];
            vo = rat[rd];
            for (int j = 0; j < k; j++) begin
                jd = in_rdst[j*AREG_W +: AREG_W];
                jp = pd[j*PREG_W +: PREG_W];
                v1 = (lane_alloc[j] && jd == a1) ? jp : v1;
                v2 = (lane_alloc[j] && jd == a2) ? jp : v2;
                vo = (lane_alloc[j] && jd == rd) ? jp : vo;
            end
            lane_alloc[k] = in_lane_valid[k] && rd != '0;
            found = 1'b0;
            sel = '0;
            for (int i = 0; i < NPREG; i++) begin
                if (!found && avail[i]) begin
                    sel = PREG_W'(i);
                    found = 1'b1;
                end
            end
            if (lane_alloc[k]) avail[sel] = 1'b0;
            s1[k*PREG_W +: PREG_W] = v1;
            s2[k*PREG_W +: PREG_W] = v2;
            pd[k*PREG_W +: PREG_W] = lane_alloc[k] ? sel : '0;
            opd[k*PREG_W +: PREG_W] = lane_alloc[k] ? vo : '0;
        end
        alloc_mask = free_vec & ~avail;
    end

    // Next speculative/committed state: commits in lane order, then rename writes, flush restores committed copy
    always_comb begin
        logic [AREG_W-1:0] ca, rd;
        logic [PREG_W-1:0] cp, co;
        crat_n = crat;
        cfree_n = cfree_vec;
        freed_mask = '0;
        rat_n = rat;
        for (int k = 0; k < WIDTH; k++) begin
            ca = commit_areg[k*AREG_W +: AREG_W];
            cp = commit_pdst[k*PREG_W +: PREG_W];
            co = crat_n[ca];
            if (commit_valid[k] && ca != '0) begin
                cfree_n[co] = 1'b1;
                freed_mask[co] = 1'b1;
                cfree_n[cp] = 1'b0;
                crat_n[ca] = cp;
            end
        end
        for (int k = 0; k < WIDTH; k++) begin
            rd = in_rdst[k*AREG_W +: AREG_W];
            if (accept && lane_alloc[k]) rat_n[rd] = pd[k*PREG_W +: PREG_W];
        end
        if (flush) rat_n = crat_n;
        free_n = flush ? cfree_n : ((free_vec & ~(accept ? alloc_mask : '0)) | freed_mask);
    end

    // Mapping tables and free vectors, identity mapping on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NAREG; i++) begin
                rat[i] <= PREG_W'(i);
                crat[i] <= PREG_W'(i);
            end
            free_vec <= FREE_INIT;
            cfree_vec <= FREE_INIT;
        end else begin
            rat <= rat_n;
            crat <= crat_n;
            free_vec <= free_n;
            cfree_vec <= cfree_n;
        end
    end

    // Output register: flush drops it, accept reloads it, otherwise held until the issue side takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_lane_valid <= '0;
            out_src1 <= '0;
            out_src2 <= '0;
            out_pdst <= '0;
            out_old_pdst <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_lane_valid <= in_lane_valid;
            out_src1 <= s1;
            out_src2 <= s2;
            out_pdst <= pd;
            out_old_pdst <= opd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/rename_dispatch.md
# rename_dispatch

Parametrised rename-and-dispatch stage for the superscalar front end, sitting between decode and the issue queues. Per cycle it renames up to WIDTH instructions: sources are looked up in a speculative register alias table (RAT) with intra-group bypass from older lanes, and each destination gets a physical register from a bit-vector free list. A committed RAT and committed free vector are maintained from the commit port, so a flush restores the speculative state in one cycle. Output is registered behind a valid/ready handshake.

## Interface
- WIDTH, 4: lanes per group (1..8)
- AREG_W, 5: architectural register index width (32 regs, r0 hard-wired zero)
- PREG_W, 6: physical register index width
- NPREG, 64: physical registers; NPREG >= 2^AREG_W + WIDTH, NPREG <= 2^PREG_W
- clk  in  1  clock; one clock domain, everything on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  group offered by decode
- in_ready  out  1  group accepted when in_valid && in_ready
- in_lane_valid  in  WIDTH  per-lane instruction present; lane 0 oldest
- in_rdst, in_src1, in_src2  in  WIDTH*AREG_W each  architectural dest/sources, lane k at bits [k*AREG_W +: AREG_W]
- out_valid  out  1  renamed group held in output register
- out_ready  in  1  issue side accepts
- out_lane_valid  out  WIDTH  registered copy of in_lane_valid
- out_src1, out_src2, out_pdst, out_old_pdst  out  WIDTH*PREG_W each  renamed sources, new dest, previous mapping of dest
- commit_valid  in  WIDTH  per-lane retire, lane 0 oldest
- commit_areg  in  WIDTH*AREG_W  retiring architectural dest
- commit_pdst  in  WIDTH*PREG_W  retiring physical dest
- flush  in  1  squash speculative state

## Operation
- Reset: RAT[i]=i and cRAT[i]=i for all arch regs; free_vec and cfree_vec bits 2^AREG_W..NPREG-1 set, others clear; output register cleared.
- Alloc lane: in_lane_valid[k] && in_rdst[k]!=0. Alloc lanes receive the lowest set bits of free_vec in lane order (lowest-indexed alloc lane gets the lowest free preg). Non-alloc lanes: out_pdst=0, out_old_pdst=0, no free bit consumed.
- Source k: if an older valid lane j<k has in_rdst[j]==src!=0, take out_pdst of the youngest such j; else RAT[src]. src==0 always yields preg 0.
- out_old_pdst[k]: same rule applied to in_rdst[k] (youngest older lane writing it, else RAT).
- On accept: RAT[rdst] updated per alloc lane, youngest lane wins; allocated bits cleared in free_vec; output register loaded.
- in_ready = (!out_valid || out_ready) && !flush && popcount(free_vec) >= WIDTH. Conservative: does not depend on in_lane_valid.
- Commit lane k with commit_areg!=0, processed in lane order: old=cRAT[areg] (including earlier same-cycle lanes); cfree_vec[old] set, free_vec[old] set, cfree_vec[pdst] cleared, cRAT[areg]=pdst. commit_areg==0 lanes ignored.
- Flush: RAT <= cRAT after this cycle's commits; free_vec <= cfree_vec after this cycle's commits; out_valid cleared; input not accepted.

## Timing
- Latency 1 cycle from accept to out_valid.
- Output fields stable while out_valid && !out_ready; load on out_ready && new accept in same cycle (full throughput).
- Commit frees visible to allocation the next cycle, never same cycle.
- Flush has priority over accept and over out_ready; out_valid=0 the cycle after flush, in_ready may rise that cycle.
- Reset values: out_valid=0, all out_* fields 0, in_ready=0 during reset, 1 on first cycle after release.
- Reset deasserted mid-stream: all in-flight state discarded, identity mapping restored.

## Test plan
- After reset, group lanes 0..3 rdst=1,2,3,4, sources r0 -> out_pdst=32,33,34,35, out_old_pdst=1,2,3,4, sources 0; out_valid one cycle later.
- Lane0 rdst=5, lane1 rdst=5, lane2 src1=5, lane3 src2=5 -> lane1 old_pdst=lane0 pdst, lane2/lane3 sources = lane1 pdst; RAT[5]=lane1 pdst.
- Rename 8 groups with out_ready=1 and no commits (NPREG=64) -> 32 pregs allocated, in_ready drops at free count 0; commit 4 lanes -> in_ready=1 next cycle, freed pregs reused lowest-first.
- Hold out_ready=0 two cycles with in_valid=1 -> outputs unchanged, in_ready=0, no allocation; release -> next group accepted same cycle.
- Rename r7->32, commit r7/32, rename r7->33, flush -> next rename of src r7 returns 32; preg 33 free again; preg 7 free.
- Flush coincident with in_valid and out_valid=1 -> group not accepted, out_valid=0 next cycle, free count unchanged apart from same-cycle commits.
